// File: rtl/irq_encoder_8to3_pkg.sv
// Shared constants and state encoding for the 8-to-3 interrupt encoder.
package irq_encoder_8to3_pkg;

  localparam int unsigned IRQ_LINES  = 8;
  localparam int unsigned IRQ_CODE_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_t;

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module prio_enc_8to3
  import irq_encoder_8to3_pkg::*;
(
  input  logic [IRQ_LINES-1:0]  vec,
  output logic                  any,
  output logic [IRQ_CODE_W-1:0] idx
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int unsigned i = 0; i < IRQ_LINES; i++) begin
      if (vec[i]) idx = IRQ_CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Registered interrupt request encoder with pending latch and valid/ack handshake.
module irq_encoder_8to3
  import irq_encoder_8to3_pkg::*;
#(
  parameter logic [IRQ_LINES-1:0] EDGE_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IRQ_LINES-1:0]  req,
  input  logic [IRQ_LINES-1:0]  mask,
  input  logic                  ack,
  output logic                  valid,
  output logic [IRQ_CODE_W-1:0] code,
  output logic [IRQ_LINES-1:0]  pending
);

  irq_state_t                state, state_n;
  logic [IRQ_LINES-1:0]      req_prev;
  logic [IRQ_LINES-1:0]      pending_n;
  logic                      cand_any;
  logic [IRQ_CODE_W-1:0]     cand_idx;
  logic [IRQ_CODE_W-1:0]     code_n;
  logic                      valid_n;

  prio_enc_8to3 u_prio (
    .vec (pending & mask),
    .any (cand_any),
    .idx (cand_idx)
  );

  // Pending next value: edge lines set on rising edge and clear on ack of
  // their own code (a coincident new edge wins); level lines track req.
  always_comb begin
    pending_n = '0;
    for (int unsigned i = 0; i < IRQ_LINES; i++) begin
      if (EDGE_MASK[i]) begin
        pending_n[i] = (req[i] & ~req_prev[i]) |
                       (pending[i] & ~(state == ST_PRESENT && ack &&
                                       code == IRQ_CODE_W'(i)));
      end else begin
        pending_n[i] = req[i];
      end
    end
  end

  // Request history and pending latch; req_prev loads req during reset so a
  // line held through reset produces no edge.
  always_ff @(posedge clk) begin
    req_prev <= req;
    if (rst) pending <= '0;
    else     pending <= pending_n;
  end

  // State, code and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      code  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      code  <= code_n;
      valid <= valid_n;
    end
  end

  // Next-state: arbitrate only in IDLE, leave PRESENT only on ack.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (cand_any) state_n = ST_PRESENT;
      ST_PRESENT: if (ack)      state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Output next values: code captured on entry to PRESENT and frozen there.
  always_comb begin
    code_n  = code;
    valid_n = valid;
    unique case (state)
      ST_IDLE: begin
        valid_n = cand_any;
        if (cand_any) code_n = cand_idx;
      end
      ST_PRESENT: if (ack) valid_n = 1'b0;
      default:    valid_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Scoreboard bench for irq_encoder_8to3 (default and mixed edge/level builds)
// plus an exhaustive check of the priority encoder.
module tb_irq_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, mask_a, req_b, mask_b;
  logic       ack_a, ack_b;
  logic       valid_a, valid_b;
  logic [2:0] code_a, code_b;
  logic [7:0] pending_a, pending_b;
  logic [7:0] pe_vec;
  logic       pe_any;
  logic [2:0] pe_idx;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];
  logic seen_a = 1'b0, seen_b = 1'b0;

  always #5 clk = ~clk;

  irq_encoder_8to3 dut_a (
    .clk(clk), .rst(rst), .req(req_a), .mask(mask_a), .ack(ack_a),
    .valid(valid_a), .code(code_a), .pending(pending_a)
  );

  irq_encoder_8to3 #(.EDGE_MASK(8'hFE)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .mask(mask_b), .ack(ack_b),
    .valid(valid_b), .code(code_b), .pending(pending_b)
  );

  prio_enc_8to3 u_pe (.vec(pe_vec), .any(pe_any), .idx(pe_idx));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: each new presentation (valid rising) is compared with the
  // next expected code from the scoreboard.
  always @(negedge clk) begin
    if (valid_a && !seen_a) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected: got code %0d expected no presentation", code_a);
      end else begin
        logic [2:0] e;
        e = exp_a.pop_front();
        if (code_a !== e) begin
          fails++;
          $display("FAIL a_code: got %0d expected %0d", code_a, e);
        end
      end
    end
    seen_a = valid_a;
    if (valid_b && !seen_b) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: got code %0d expected no presentation", code_b);
      end else begin
        logic [2:0] e;
        e = exp_b.pop_front();
        if (code_b !== e) begin
          fails++;
          $display("FAIL b_code: got %0d expected %0d", code_b, e);
        end
      end
    end
    seen_b = valid_b;
  end

  initial begin
    // Exhaustive priority encoder: highest set bit = clog2(v+1)-1.
    for (int v = 0; v < 256; v++) begin
      logic [7:0] e;
      pe_vec = v[7:0];
      #1;
      e = (v == 0) ? 8'h00 : {4'h0, 1'b1, 3'($clog2(v + 1) - 1)};
      chk("prio_enc", {4'h0, pe_any, pe_idx}, e);
    end

    rst = 1'b1; req_a = '0; mask_a = 8'hFF; ack_a = 1'b0;
    req_b = '0; mask_b = 8'hFF; ack_b = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_valid", {7'd0, valid_a}, 8'h00);
    chk("rst_code", {5'd0, code_a}, 8'h00);
    chk("rst_pending", pending_a, 8'h00);
    step(1);

    // Single edge request on line 3.
    req_a = 8'h08; exp_a.push_back(3'd3);
    step(1);
    chk("t1_pending", pending_a, 8'h08);
    chk("t1_valid_k", {7'd0, valid_a}, 8'h00);
    step(1);
    chk("t1_valid_k1", {7'd0, valid_a}, 8'h01);
    chk("t1_code", {5'd0, code_a}, 8'h03);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0; req_a = 8'h00;
    chk("t1_valid_ack", {7'd0, valid_a}, 8'h00);
    chk("t1_pending_ack", pending_a, 8'h00);
    step(1);

    // Two lines at once: 5 then 2.
    req_a = 8'h24; exp_a.push_back(3'd5); exp_a.push_back(3'd2);
    step(1);
    chk("t2_pending", pending_a, 8'h24);
    step(1);
    chk("t2_code5", {5'd0, code_a}, 8'h05);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0;
    chk("t2_gap_valid", {7'd0, valid_a}, 8'h00);
    chk("t2_gap_pending", pending_a, 8'h04);
    step(1);
    chk("t2_valid2", {7'd0, valid_a}, 8'h01);
    chk("t2_code2", {5'd0, code_a}, 8'h02);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0; req_a = 8'h00;
    chk("t2_pending_end", pending_a, 8'h00);
    step(1);

    // Masked line stays pending but unpresented.
    mask_a = 8'hF7; req_a = 8'h08;
    step(1);
    chk("t3_pending", pending_a, 8'h08);
    step(2);
    chk("t3_masked_valid", {7'd0, valid_a}, 8'h00);
    mask_a = 8'hFF; exp_a.push_back(3'd3);
    step(2);
    chk("t3_unmask_valid", {7'd0, valid_a}, 8'h01);
    chk("t3_unmask_code", {5'd0, code_a}, 8'h03);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0; req_a = 8'h00;
    step(1);

    // New edge on the presented line coincident with ack: set wins.
    req_a = 8'h10; exp_a.push_back(3'd4);
    step(2);
    chk("t5_code4", {5'd0, code_a}, 8'h04);
    req_a = 8'h00;
    step(1);
    req_a = 8'h10; ack_a = 1'b1; exp_a.push_back(3'd4);
    step(1);
    ack_a = 1'b0;
    chk("t5_ack_valid", {7'd0, valid_a}, 8'h00);
    chk("t5_keep_pending", pending_a, 8'h10);
    step(1);
    chk("t5_represent", {7'd0, valid_a}, 8'h01);
    // Higher line 6 during PRESENT does not preempt.
    req_a = 8'h50;
    step(1);
    chk("t5_pending56", pending_a, 8'h50);
    chk("t5_hold_code", {5'd0, code_a}, 8'h04);
    step(1);
    chk("t5_hold_code2", {5'd0, code_a}, 8'h04);
    exp_a.push_back(3'd6); ack_a = 1'b1;
    step(1);
    ack_a = 1'b0;
    chk("t5_pending6", pending_a, 8'h40);
    step(1);
    chk("t5_code6", {5'd0, code_a}, 8'h06);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0; req_a = 8'h00;
    chk("t5_pending_end", pending_a, 8'h00);
    step(1);

    // Reset while presenting line 7 held high.
    req_a = 8'h80; exp_a.push_back(3'd7);
    step(2);
    chk("t6_valid", {7'd0, valid_a}, 8'h01);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_valid", {7'd0, valid_a}, 8'h00);
    chk("t6_rst_code", {5'd0, code_a}, 8'h00);
    chk("t6_rst_pending", pending_a, 8'h00);
    step(3);
    chk("t6_no_edge_valid", {7'd0, valid_a}, 8'h00);
    chk("t6_no_edge_pending", pending_a, 8'h00);
    req_a = 8'h00;
    step(1);
    req_a = 8'h80; exp_a.push_back(3'd7);
    step(2);
    chk("t6_re_code", {5'd0, code_a}, 8'h07);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0; req_a = 8'h00;
    step(1);

    // Level-triggered line 0 on the second build.
    req_b = 8'h01; exp_b.push_back(3'd0);
    step(1);
    chk("lv_pending", pending_b, 8'h01);
    step(1);
    chk("lv_valid", {7'd0, valid_b}, 8'h01);
    ack_b = 1'b1;
    step(1);
    ack_b = 1'b0; exp_b.push_back(3'd0);
    chk("lv_ack_valid", {7'd0, valid_b}, 8'h00);
    chk("lv_ack_pending", pending_b, 8'h01);
    step(1);
    chk("lv_represent", {7'd0, valid_b}, 8'h01);
    req_b = 8'h00;
    step(1);
    chk("lv_drop_pending", pending_b, 8'h00);
    chk("lv_drop_valid", {7'd0, valid_b}, 8'h01);
    step(1);
    chk("lv_drop_code", {5'd0, code_b}, 8'h00);
    ack_b = 1'b1;
    step(1);
    ack_b = 1'b0;
    step(2);
    chk("lv_after_valid", {7'd0, valid_b}, 8'h00);

    step(1);
    chk("sb_a_empty", 8'(exp_a.size()), 8'h00);
    chk("sb_b_empty", 8'(exp_b.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
